// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and writeback stage (optional macro: WB_RETIRE_CNT_EN)
module wb_stage #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] RST_PC4 = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_tock,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wbsel,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_load,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_imm,
  output logic [4:0]      writereg_addr,
  output logic [XLEN-1:0] writedata,
  output logic            regwrite,
  output logic            wb_valid,
  output logic            misalign_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  logic            cap;
  logic            wb_valid_q;
  logic            wb_regwrite_q;
  logic [4:0]      wb_rd_q;
  logic [1:0]      wb_wbsel_q;
  logic [2:0]      wb_funct3_q;
  logic [1:0]      wb_addr_lo_q;
  logic [XLEN-1:0] wb_alu_q;
  logic [XLEN-1:0] wb_load_q;
  logic [XLEN-1:0] wb_pc4_q;
  logic [XLEN-1:0] wb_imm_q;
  logic            misalign_err_q;

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_fmt;
  logic            load_misaligned;
  logic            load_illegal;
  logic            load_fault;

  // The stage only moves on the capture phase, and a stall freezes it even then.
  assign cap = tick_tock & ~stall;

  // Pipeline register: a flush drops the incoming instruction to a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_wbsel_q    <= '0;
      wb_funct3_q   <= '0;
      wb_addr_lo_q  <= '0;
      wb_alu_q      <= '0;
      wb_load_q     <= '0;
      wb_pc4_q      <= RST_PC4;
      wb_imm_q      <= '0;
    end else if (cap) begin
      if (flush) begin
        wb_valid_q    <= 1'b0;
        wb_regwrite_q <= 1'b0;
      end else begin
        wb_valid_q    <= mem_valid;
        wb_regwrite_q <= mem_regwrite;
        wb_rd_q       <= mem_rd;
        wb_wbsel_q    <= mem_wbsel;
        wb_funct3_q   <= mem_funct3;
        wb_addr_lo_q  <= mem_addr_lo;
        wb_alu_q      <= mem_alu;
        wb_load_q     <= mem_load;
        wb_pc4_q      <= mem_pc4;
        wb_imm_q      <= mem_imm;
      end
    end
  end

  // Lane extraction and fault detection for the registered load.
  always_comb begin
    load_byte       = wb_load_q[7:0];
    load_half       = wb_addr_lo_q[1] ? wb_load_q[31:16] : wb_load_q[15:0];
    load_fmt        = '0;
    load_misaligned = 1'b0;
    load_illegal    = 1'b0;
    case (wb_addr_lo_q)
      2'd0:    load_byte = wb_load_q[7:0];
      2'd1:    load_byte = wb_load_q[15:8];
      2'd2:    load_byte = wb_load_q[23:16];
      default: load_byte = wb_load_q[31:24];
    endcase
    case (wb_funct3_q)
      3'b000: load_fmt = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100: load_fmt = {{(XLEN-8){1'b0}}, load_byte};
      3'b001: begin
        load_fmt        = {{(XLEN-16){load_half[15]}}, load_half};
        load_misaligned = wb_addr_lo_q[0];
      end
      3'b101: begin
        load_fmt        = {{(XLEN-16){1'b0}}, load_half};
        load_misaligned = wb_addr_lo_q[0];
      end
      3'b010: begin
        load_fmt        = wb_load_q;
        load_misaligned = (wb_addr_lo_q != 2'd0);
      end
      default: load_illegal = 1'b1;
    endcase
  end

  // Only the load source can fault; other sources ignore funct3/addr_lo.
  assign load_fault = (wb_wbsel_q == WB_LOAD) & (load_misaligned | load_illegal);

  // Writeback source select; a faulting load writes zero.
  always_comb begin
    writedata = wb_alu_q;
    case (wb_wbsel_q)
      WB_ALU:  writedata = wb_alu_q;
      WB_LOAD: writedata = load_fault ? '0 : load_fmt;
      WB_PC4:  writedata = wb_pc4_q;
      WB_IMM:  writedata = wb_imm_q;
      default: writedata = wb_alu_q;
    endcase
  end

  assign writereg_addr = wb_rd_q;
  assign wb_valid      = wb_valid_q;
  assign regwrite      = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0) & ~load_fault;

  // Sticky fault flag, set as the faulting load leaves the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err_q <= 1'b0;
    end else if (cap && wb_valid_q && load_fault) begin
      misalign_err_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count_q;

  // Count clean instructions as they leave; bubbles (incl. flushed ones) never count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_count_q <= '0;
    end else if (cap && wb_valid_q && !load_fault && (retire_count_q != 32'hFFFF_FFFF)) begin
      retire_count_q <= retire_count_q + 32'd1;
    end
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_tock;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu;
  logic [31:0] mem_load;
  logic [31:0] mem_pc4;
  logic [31:0] mem_imm;
  logic [4:0]  writereg_addr;
  logic [31:0] writedata;
  logic        regwrite;
  logic        wb_valid;
  logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int checks   = 0;
  int failures = 0;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .tick_tock     (tick_tock),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_regwrite  (mem_regwrite),
    .mem_rd        (mem_rd),
    .mem_wbsel     (mem_wbsel),
    .mem_funct3    (mem_funct3),
    .mem_addr_lo   (mem_addr_lo),
    .mem_alu       (mem_alu),
    .mem_load      (mem_load),
    .mem_pc4       (mem_pc4),
    .mem_imm       (mem_imm),
    .writereg_addr (writereg_addr),
    .writedata     (writedata),
    .regwrite      (regwrite),
    .wb_valid      (wb_valid),
    .misalign_err  (misalign_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rw;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] e_addr,
                     input logic [31:0] e_data, input logic e_rw, input logic e_valid,
                     input logic e_mis);
    vec_t t;
    t = '{v, rw, rd, sel, f3, lo, alu, pc4, imm, e_addr, e_data, e_rw, e_valid, e_mis};
    vecs.push_back(t);
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu);
    mem_valid    = v;
    mem_regwrite = rw;
    mem_rd       = rd;
    mem_wbsel    = sel;
    mem_funct3   = f3;
    mem_addr_lo  = lo;
    mem_alu      = alu;
  endtask

  // One clock with the given phase/control; returns 1 time unit after the edge.
  task automatic step(input logic tt, input logic st, input logic fl);
    tick_tock = tt;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_mem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0);
    mem_load = 32'h80FF_7F01;
    mem_pc4  = 32'h0;
    mem_imm  = 32'h0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Reset state
    chk("rst_addr", {27'd0, writereg_addr}, 32'd0);
    chk("rst_data", writedata, 32'd0);
    chk("rst_rw", {31'd0, regwrite}, 32'd0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    rst = 1'b1;

    //  v     rw    rd     sel    f3      lo    alu            pc4           imm            e_addr e_data         e_rw  e_val e_mis
    add(1'b1, 1'b1, 5'd5,  2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'h0,        32'h0,         5'd5,  32'h1234_5678, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd1,  2'b01, 3'b000, 2'd3, 32'h0,         32'h0,        32'h0,         5'd1,  32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd2,  2'b01, 3'b100, 2'd1, 32'h0,         32'h0,        32'h0,         5'd2,  32'h0000_007F, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd3,  2'b01, 3'b001, 2'd2, 32'h0,         32'h0,        32'h0,         5'd3,  32'hFFFF_80FF, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd4,  2'b01, 3'b101, 2'd2, 32'h0,         32'h0,        32'h0,         5'd4,  32'h0000_80FF, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd6,  2'b01, 3'b010, 2'd0, 32'h0,         32'h0,        32'h0,         5'd6,  32'h80FF_7F01, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd14, 2'b01, 3'b001, 2'd0, 32'h0,         32'h0,        32'h0,         5'd14, 32'h0000_7F01, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd8,  2'b10, 3'b000, 2'd0, 32'h0,         32'h0000_0100, 32'h0,        5'd8,  32'h0000_0100, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd9,  2'b11, 3'b000, 2'd0, 32'h0,         32'h0,        32'hABCD_E000, 5'd9,  32'hABCD_E000, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 2'd0, 32'h0000_0055, 32'h0,        32'h0,         5'd0,  32'h0000_0055, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 5'd10, 2'b00, 3'b000, 2'd0, 32'h0000_0066, 32'h0,        32'h0,         5'd10, 32'h0000_0066, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 5'd11, 2'b00, 3'b000, 2'd0, 32'h0000_0077, 32'h0,        32'h0,         5'd11, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 5'd12, 2'b01, 3'b011, 2'd0, 32'h0,         32'h0,        32'h0,         5'd12, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 2'd0, 32'h0000_0001, 32'h0,        32'h0,         5'd13, 32'h0000_0001, 1'b1, 1'b1, 1'b1);

    foreach (vecs[i]) begin
      mem_valid    = vecs[i].v;
      mem_regwrite = vecs[i].rw;
      mem_rd       = vecs[i].rd;
      mem_wbsel    = vecs[i].sel;
      mem_funct3   = vecs[i].f3;
      mem_addr_lo  = vecs[i].lo;
      mem_alu      = vecs[i].alu;
      mem_pc4      = vecs[i].pc4;
      mem_imm      = vecs[i].imm;
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("v%0d_addr", i), {27'd0, writereg_addr}, {27'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_data", i), writedata, vecs[i].e_data);
      chk($sformatf("v%0d_rw", i), {31'd0, regwrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_valid", i), {31'd0, wb_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
    end

    // Asynchronous reset in the middle of an active write
    tick_tock = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rw", {31'd0, regwrite}, 32'd0);
    chk("arst_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_mis", {31'd0, misalign_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("arst_rel_data", writedata, 32'd0);
    chk("arst_rel_addr", {27'd0, writereg_addr}, 32'd0);

    // Misaligned LW: suppressed now, sticky flag on the next capture
    set_mem(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 2'd2, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("mlw_rw", {31'd0, regwrite}, 32'd0);
    chk("mlw_data", writedata, 32'd0);
    chk("mlw_mis_pre", {31'd0, misalign_err}, 32'd0);
    set_mem(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'd0, 32'h0000_0009);
    step(1'b1, 1'b0, 1'b0);
    chk("mlw_mis_set", {31'd0, misalign_err}, 32'd1);
    chk("mlw_next_data", writedata, 32'h0000_0009);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("mlw_mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Stall holds a valid write for 3 cycles
    set_mem(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h1234_5678);
    step(1'b1, 1'b0, 1'b0);
    set_mem(1'b1, 1'b1, 5'd20, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("stall%0d_addr", c), {27'd0, writereg_addr}, 32'd5);
      chk($sformatf("stall%0d_data", c), writedata, 32'h1234_5678);
      chk($sformatf("stall%0d_rw", c), {31'd0, regwrite}, 32'd1);
    end

    // Stall and flush together: stall wins
    step(1'b1, 1'b1, 1'b1);
    chk("stfl_valid", {31'd0, wb_valid}, 32'd1);
    chk("stfl_data", writedata, 32'h1234_5678);

    // Flush outside the capture phase is ignored
    step(1'b0, 1'b0, 1'b1);
    chk("fl_nocap_valid", {31'd0, wb_valid}, 32'd1);
    chk("fl_nocap_rw", {31'd0, regwrite}, 32'd1);

    // Flush with capture inserts a bubble
    step(1'b1, 1'b0, 1'b1);
    chk("flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_rw", {31'd0, regwrite}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback stage for the pipelined RISC-V core.
- Latches memory-stage results on the capture phase of tick_tock and selects the writeback source.
- Aligns and extends load data, then drives the register file's writereg_addr, writedata and regwrite inputs.
- Suppresses writes for bubbles, x0 targets and misaligned or illegal loads, and flags those faults.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RST_PC4, 32'h0000_0004, reset value held in the stage's pc4 register.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- tick_tock  in  1  phase signal; stage captures when 1; register file writes when 0
- stall  in  1  hold stage contents
- flush  in  1  replace incoming instruction with a bubble
- mem_valid  in  1  MEM stage holds a real instruction
- mem_regwrite  in  1  instruction writes rd
- mem_rd  in  5  destination register
- mem_wbsel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- mem_funct3  in  3  load width/sign code
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_alu  in  32  ALU result
- mem_load  in  32  raw word read from data memory
- mem_pc4  in  32  PC+4
- mem_imm  in  32  U-type immediate
- writereg_addr  out  5  to register file
- writedata  out  32  to register file
- regwrite  out  1  to register file
- wb_valid  out  1  stage holds a real instruction
- misalign_err  out  1  sticky fault flag

Behaviour:
- Reset (rst=0, asynchronous): clear all stage registers, wb_valid and misalign_err to 0; pc4 register loads RST_PC4. Outputs then read writereg_addr=0, writedata=0, regwrite=0. Release is synchronous to the next clk edge.
- Capture enable: cap = tick_tock & ~stall.
- On a posedge with cap=1:
  - flush=1: wb_valid<=0 and wb_regwrite<=0; other fields are don't-care. Flush takes priority over valid input.
  - flush=0: all mem_* fields are registered, and wb_valid<=mem_valid.
- On a posedge with cap=0, all stage registers hold. flush is ignored when cap=0.
- Latency: one capture edge from MEM to writeback outputs. The register file consumes the outputs on the following tick_tock=0 edge.
- writedata is combinational from the stage registers, selected by wbsel.
- Load formatting (wbsel=01), using the registered addr_lo to pick the byte/half lane:
  - 000 LB: sign-extend byte[addr_lo].
  - 100 LBU: zero-extend byte[addr_lo].
  - 001 LH: sign-extend half[addr_lo[1]].
  - 101 LHU: zero-extend half[addr_lo[1]].
  - 010 LW: full word.
- Load fault conditions:
  - Misaligned: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
  - Illegal funct3: 011, 110, 111.
  - On either fault: writedata=0 and the write is suppressed.
- regwrite = wb_valid & wb_regwrite & (writereg_addr!=0) & ~load_fault.
  - rd=x0 never asserts regwrite; writedata is still driven.
- misalign_err:
  - Set on the capture edge following a registered valid faulting load.
  - Stays set until reset.
  - Never set by bubbles or non-load instructions.
- Stall while holding a valid instruction: outputs stay stable and regwrite stays asserted. A repeated write of the same value is harmless.
- Simultaneous stall=1 and flush=1: stall wins; no capture.
- Reset asserted mid-write: regwrite drops immediately (asynchronous).

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count [31:0], reset to 0.
  - Increments by 1 on every capture edge where the instruction leaving the stage has wb_valid=1 and no load fault.
  - Saturates at 32'hFFFF_FFFF.
  - A stall or flush does not increment the counter.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 mid-run -> regwrite=0, wb_valid=0, misalign_err=0 immediately; writedata=0 after release.
- ALU writeback: tick_tock=1 edge with mem_valid=1, regwrite=1, rd=5, wbsel=00, alu=32'h1234_5678 -> writereg_addr=5, writedata=32'h1234_5678, regwrite=1.
- Loads: mem_load=32'h80FF_7F01 with LB at addr_lo=3 -> 32'hFFFF_FF80; LBU at addr_lo=1 -> 32'h0000_007F; LH at addr_lo=2 -> 32'hFFFF_80FF.
- Misaligned LW: addr_lo=2, rd=7 -> regwrite=0, writedata=0; misalign_err=1 after the next capture edge and remains 1.
- x0, flush and stall: rd=0 -> regwrite=0. flush=1 with cap -> wb_valid=0. stall=1 for 3 cycles -> outputs unchanged. stall+flush together -> no change.
- Retire counter (WB_RETIRE_CNT_EN): 4 valid instructions, 1 bubble and 1 faulting load -> retire_count=4.
